obq_gh: RTL and testbench
=========================

OBQ_GH -- requirements
Module: obq_gh

Interface
REQ-001 The block SHALL have parameter GHT_BIT, default 4: global history width, matching the gshare predictor.
REQ-002 The block SHALL have parameter DEPTH, default 8: number of checkpoint entries; a power of 2 and at least 2.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-005 The block SHALL have port push_en, input, 1 bit: a predicted branch was issued this cycle.
REQ-006 The block SHALL have port push_gh, input, GHT_BIT bits: predictor history value used to index the PHT for that branch (pre-update GHT).
REQ-007 The block SHALL have port resolve_en, input, 1 bit: the oldest outstanding branch resolved this cycle.
REQ-008 The block SHALL have port resolve_mispredict, input, 1 bit: qualifies resolve_en; the prediction was wrong.
REQ-009 The block SHALL have port obq_bh_pred_valid, output, 1 bit: obq_gh_out is meaningful.
REQ-010 The block SHALL have port obq_gh_out, output, GHT_BIT bits: checkpointed history (head entry, or rollback value).
REQ-011 The block SHALL have port clear_en, output, 1 bit: rollback pulse to the predictor.
REQ-012 The block SHALL have port full, output, 1 bit: count==DEPTH.
REQ-013 The block SHALL have port empty, output, 1 bit: count==0.
REQ-014 The block SHALL have port count, output, clog2(DEPTH)+1 bits: occupied entries.
REQ-015 The block SHALL have port err_ovf, output, 1 bit: sticky; a push was dropped while full.
REQ-016 The block SHALL have port err_udf, output, 1 bit: sticky; a resolve arrived while empty.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries, each GHT_BIT wide, with head and tail pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 The FSM SHALL have two states: NORMAL and ROLLBACK.
REQ-019 In NORMAL, a push (push_en and not full, or push_en and full with a same-cycle good resolve) SHALL write push_gh at tail, advance tail and increment count.
REQ-020 In NORMAL, a good resolve (resolve_en, !resolve_mispredict, !empty) SHALL advance head and decrement count.
REQ-021 On a simultaneous push and good resolve, both SHALL occur and count SHALL be unchanged; this includes the full case.
REQ-022 In NORMAL, a mispredict (resolve_en, resolve_mispredict, !empty) SHALL capture entry[head] into a rollback register, reset head, tail and count to 0, drop any same-cycle push, and go to ROLLBACK.
REQ-023 ROLLBACK SHALL last exactly one cycle, then return to NORMAL; in it clear_en=1, obq_bh_pred_valid=1 and obq_gh_out=rollback register.
REQ-024 In ROLLBACK, push_en and resolve_en SHALL be ignored and SHALL NOT set the error flags.
REQ-025 In NORMAL, clear_en SHALL be 0, obq_bh_pred_valid SHALL equal !empty, and obq_gh_out SHALL be entry[head] when !empty and 0 when empty.
REQ-026 A push while full with no same-cycle good resolve SHALL be dropped and SHALL set err_ovf.
REQ-027 Any resolve_en while empty in NORMAL SHALL be ignored and SHALL set err_udf.
REQ-028 All outputs SHALL be derived from registered state only, with no combinational path from inputs.

Reset
REQ-029 When reset==0 at a rising edge: state=NORMAL, head=tail=count=0, rollback register=0, err_ovf=err_udf=0; storage contents need not be cleared.
REQ-030 Output values after reset: clear_en=0, obq_bh_pred_valid=0, obq_gh_out=0, empty=1, full=0, count=0.
REQ-031 Reset SHALL take priority over every other input, including mid-ROLLBACK; the next cycle is NORMAL with no clear_en pulse.

Verification
REQ-032 Reset, then push gh 3,5,9 on consecutive cycles -> count=3, obq_gh_out=3, obq_bh_pred_valid=1, clear_en=0.
REQ-033 From REQ-032, one good resolve -> count=2, obq_gh_out=5; resolve with mispredict -> next cycle clear_en=1, obq_gh_out=5, count=0; the following cycle clear_en=0, empty=1.
REQ-034 Fill 8 entries (gh 0..7), push gh 15 with no resolve -> dropped, err_ovf=1, count=8; then push gh 15 with a good resolve -> count=8, head gh=1, tail entry=15.
REQ-035 Run 20 push/resolve pairs to wrap the pointers twice -> each head value matches FIFO order; count never exceeds 8.
REQ-036 Mispredict with push_en=1 in the same cycle -> push dropped, count=0 after ROLLBACK; resolve_en during ROLLBACK -> ignored, err_udf stays 0.
REQ-037 reset=0 during the ROLLBACK cycle -> next cycle clear_en=0, empty=1, err flags 0; resolve_en while empty -> err_udf=1.

Source files
------------

// File: rtl/obq_gh.sv
// Outstanding-branch queue holding global-history checkpoints for a gshare predictor.
// Each entry is the pre-update history of one in-flight branch. A mispredict replays the oldest entry through a single rollback cycle.
module obq_gh #(
    parameter int GHT_BIT = 4,
    parameter int DEPTH   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_en,
    input  logic [GHT_BIT-1:0]       push_gh,
    input  logic                     resolve_en,
    input  logic                     resolve_mispredict,
    output logic                     obq_bh_pred_valid,
    output logic [GHT_BIT-1:0]       obq_gh_out,
    output logic                     clear_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_ovf,
    output logic                     err_udf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        ROLLBACK = 1'b1
    } state_t;

    state_t               state_r, state_s;
    logic [GHT_BIT-1:0]   mem_r [DEPTH];
    logic [PW-1:0]        head_r, head_s, tail_r, tail_s;
    logic [CW-1:0]        count_r, count_s;
    logic [GHT_BIT-1:0]   rb_r, rb_s;
    logic                 err_ovf_r, err_ovf_s, err_udf_r, err_udf_s;
    logic                 empty_now_s, full_now_s, good_s, mis_s, wr_s;
    logic                 clear_en_r, clear_en_s, valid_r, valid_s;
    logic [GHT_BIT-1:0]   gh_out_r, gh_out_s;
    logic                 full_r, full_s, empty_r, empty_s;

    // Next-state, pointer/count update and the registered view of the head.
    always_comb begin
        state_s     = state_r;
        head_s      = head_r;
        tail_s      = tail_r;
        count_s     = count_r;
        rb_s        = rb_r;
        err_ovf_s   = err_ovf_r;
        err_udf_s   = err_udf_r;
        empty_now_s = (count_r == {CW{1'b0}});
        full_now_s  = (count_r == CW'(DEPTH));
        good_s      = 1'b0;
        mis_s       = 1'b0;
        wr_s        = 1'b0;
        case (state_r)
            NORMAL: begin
                good_s = resolve_en && !resolve_mispredict && !empty_now_s;
                mis_s  = resolve_en && resolve_mispredict && !empty_now_s;
                if (resolve_en && empty_now_s) begin
                    err_udf_s = 1'b1;
                end else begin
                    err_udf_s = err_udf_r;
                end
                if (push_en && full_now_s && !good_s) begin
                    err_ovf_s = 1'b1;
                end else begin
                    err_ovf_s = err_ovf_r;
                end
                if (mis_s) begin
                    rb_s    = mem_r[head_r];
                    head_s  = {PW{1'b0}};
                    tail_s  = {PW{1'b0}};
                    count_s = {CW{1'b0}};
                    state_s = ROLLBACK;
                end else begin
                    wr_s   = push_en && (!full_now_s || good_s);
                    tail_s = wr_s ? (tail_r + PW'(1'b1)) : tail_r;
                    head_s = good_s ? (head_r + PW'(1'b1)) : head_r;
                    if (wr_s && !good_s) begin
                        count_s = count_r + CW'(1'b1);
                    end else if (good_s && !wr_s) begin
                        count_s = count_r - CW'(1'b1);
                    end else begin
                        count_s = count_r;
                    end
                end
            end
            ROLLBACK: begin
                state_s = NORMAL;
            end
            default: begin
                state_s = NORMAL;
            end
        endcase

        // A push into the slot that becomes head must be forwarded, it is not in mem_r yet.
        if (state_s == ROLLBACK) begin
            clear_en_s = 1'b1;
            valid_s    = 1'b1;
            gh_out_s   = rb_s;
        end else if (count_s != {CW{1'b0}}) begin
            clear_en_s = 1'b0;
            valid_s    = 1'b1;
            gh_out_s   = (wr_s && (head_s == tail_r)) ? push_gh : mem_r[head_s];
        end else begin
            clear_en_s = 1'b0;
            valid_s    = 1'b0;
            gh_out_s   = {GHT_BIT{1'b0}};
        end
        full_s  = (count_s == CW'(DEPTH));
        empty_s = (count_s == {CW{1'b0}});
    end

    // Control state and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r    <= NORMAL;
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            rb_r       <= {GHT_BIT{1'b0}};
            err_ovf_r  <= 1'b0;
            err_udf_r  <= 1'b0;
            clear_en_r <= 1'b0;
            valid_r    <= 1'b0;
            gh_out_r   <= {GHT_BIT{1'b0}};
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            head_r     <= head_s;
            tail_r     <= tail_s;
            count_r    <= count_s;
            rb_r       <= rb_s;
            err_ovf_r  <= err_ovf_s;
            err_udf_r  <= err_udf_s;
            clear_en_r <= clear_en_s;
            valid_r    <= valid_s;
            gh_out_r   <= gh_out_s;
            full_r     <= full_s;
            empty_r    <= empty_s;
        end
    end

    // Checkpoint storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (reset && wr_s) begin
            mem_r[tail_r] <= push_gh;
        end
    end

    assign obq_bh_pred_valid = valid_r;
    assign obq_gh_out        = gh_out_r;
    assign clear_en          = clear_en_r;
    assign full              = full_r;
    assign empty             = empty_r;
    assign count             = count_r;
    assign err_ovf           = err_ovf_r;
    assign err_udf           = err_udf_r;

endmodule

// File: tb/tb_obq_gh.sv
// Self-checking bench for obq_gh: directed vector table, hand sequences for reset/rollback,
// and randomized traffic checked against a queue-based reference model.
module tb_obq_gh;

    localparam int GHT_BIT = 4;
    localparam int DEPTH   = 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               push_en = 1'b0;
    logic [GHT_BIT-1:0] push_gh = '0;
    logic               resolve_en = 1'b0;
    logic               resolve_mispredict = 1'b0;
    logic               obq_bh_pred_valid;
    logic [GHT_BIT-1:0] obq_gh_out;
    logic               clear_en, full, empty, err_ovf, err_udf;
    logic [CW-1:0]      count;

    obq_gh #(.GHT_BIT(GHT_BIT), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .push_en(push_en), .push_gh(push_gh),
        .resolve_en(resolve_en), .resolve_mispredict(resolve_mispredict),
        .obq_bh_pred_valid(obq_bh_pred_valid), .obq_gh_out(obq_gh_out),
        .clear_en(clear_en), .full(full), .empty(empty), .count(count),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic p; logic [3:0] g; logic r; logic m;
        int cnt; logic [3:0] out; logic valid; logic clr; logic ovf; logic udf;
    } vec_t;
    vec_t vecs[$];

    // reference model state
    int         q[$];
    bit         rbp;
    logic [3:0] rbv;
    bit         movf, mudf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int cnt, input logic [3:0] out,
                              input logic valid, input logic clr, input logic ovf, input logic udf);
        check({tag, ".count"}, 32'(count), cnt);
        check({tag, ".gh_out"}, 32'(obq_gh_out), 32'(out));
        check({tag, ".valid"}, 32'(obq_bh_pred_valid), 32'(valid));
        check({tag, ".clear_en"}, 32'(clear_en), 32'(clr));
        check({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
        check({tag, ".full"}, 32'(full), 32'(cnt == DEPTH));
        check({tag, ".err_ovf"}, 32'(err_ovf), 32'(ovf));
        check({tag, ".err_udf"}, 32'(err_udf), 32'(udf));
    endtask

    task automatic drive(input logic p, input logic [3:0] g, input logic r, input logic m, input logic rst);
        push_en = p; push_gh = g; resolve_en = r; resolve_mispredict = m; reset = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic p, input logic [3:0] g, input logic r, input logic m, input int cnt,
                       input logic [3:0] out, input logic valid, input logic clr, input logic ovf, input logic udf);
        vec_t v;
        v.p = p; v.g = g; v.r = r; v.m = m; v.cnt = cnt; v.out = out;
        v.valid = valid; v.clr = clr; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    // Drives one cycle, advances the model from its queue-level rules, then compares.
    task automatic mstep(input logic p, input logic [3:0] g, input logic r, input logic m,
                         input logic rst, input string tag);
        bit was_empty, was_full, good, mis;
        drive(p, g, r, m, rst);
        if (!rst) begin
            q.delete(); rbp = 0; rbv = 4'd0; movf = 0; mudf = 0;
        end else if (rbp) begin
            rbp = 0;
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            good = r && !m && !was_empty;
            mis  = r && m && !was_empty;
            if (r && was_empty) mudf = 1;
            if (p && was_full && !good) movf = 1;
            if (mis) begin
                rbv = 4'(q[0]);
                q.delete();
                rbp = 1;
            end else begin
                if (good) void'(q.pop_front());
                if (p && (!was_full || good)) q.push_back(int'(g));
            end
        end
        if (rbp) check_outs(tag, 0, rbv, 1'b1, 1'b1, movf, mudf);
        else check_outs(tag, q.size(), (q.size() > 0) ? 4'(q[0]) : 4'd0,
                        q.size() > 0, 1'b0, movf, mudf);
    endtask

    initial begin
        // directed table: basic flow, overflow, full push+resolve, drain, mispredict with push
        add(1, 3, 0, 0, 1, 3, 1, 0, 0, 0);
        add(1, 5, 0, 0, 2, 3, 1, 0, 0, 0);
        add(1, 9, 0, 0, 3, 3, 1, 0, 0, 0);
        add(0, 0, 1, 0, 2, 5, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0, 5, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 4'(i), 0, 0, i + 1, 0, 1, 0, 0, 0);
        add(1, 15, 0, 0, 8, 0, 1, 0, 1, 0);
        add(1, 15, 1, 0, 8, 1, 1, 0, 1, 0);
        for (int k = 1; k <= 6; k++) add(0, 0, 1, 0, 8 - k, 4'(k + 1), 1, 0, 1, 0);
        add(0, 0, 1, 0, 1, 15, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 4, 0, 0, 1, 4, 1, 0, 1, 0);
        add(1, 6, 0, 0, 2, 4, 1, 0, 1, 0);
        add(1, 11, 1, 1, 0, 4, 1, 1, 1, 0);
        add(1, 12, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        foreach (vecs[i]) begin
            drive(vecs[i].p, vecs[i].g, vecs[i].r, vecs[i].m, 1);
            check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].out, vecs[i].valid,
                       vecs[i].clr, vecs[i].ovf, vecs[i].udf);
        end

        // reset asserted during the rollback cycle
        drive(1, 2, 0, 0, 1);
        check_outs("rb_rst.push", 1, 2, 1, 0, 1, 0);
        drive(0, 0, 1, 1, 1);
        check_outs("rb_rst.rollback", 0, 2, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0);
        check_outs("rb_rst.reset", 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        check_outs("rb_rst.udf", 0, 0, 0, 0, 0, 1);

        // pointer wrap: 3 pre-filled entries then 20 push+resolve pairs
        mstep(0, 0, 0, 0, 0, "wrap.reset");
        for (int i = 0; i < 3; i++) mstep(1, 4'(i + 1), 0, 0, 1, $sformatf("wrap.fill%0d", i));
        for (int i = 0; i < 20; i++) begin
            mstep(1, 4'($urandom_range(0, 15)), 1, 0, 1, $sformatf("wrap.pair%0d", i));
            check($sformatf("wrap.bound%0d", i), 32'(count <= CW'(DEPTH)), 32'd1);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            mstep($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 59) != 0, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
